// File: rtl/rec_trigger_sequencer.sv
// Trace-recorder sequencer: arm, pre-trigger fill, pulse-width trigger qualification,
// post-trigger count, readout wait and holdoff. All outputs registered.
module rec_trigger_sequencer #(
  parameter int QUAL_W = 4,
  parameter int HOLD_W = 16
) (
  input  logic              clk8M,
  input  logic              reset_n,
  input  logic              cfg_enable,
  input  logic              cfg_auto_rearm,
  input  logic [5:0]        cfg_mask,
  input  logic [QUAL_W-1:0] cfg_qual_len,
  input  logic [7:0]        cfg_depth,
  input  logic [HOLD_W-1:0] cfg_holdoff,
  input  logic [5:0]        det,
  input  logic              arm_pulse,
  input  logic              abort_pulse,
  input  logic              host_ack,
  input  logic              rd_done_tgl,
  output logic [5:0]        rec_det,
  output logic [7:0]        rec_ctl,
  output logic [2:0]        state_o,
  output logic [5:0]        trig_chan,
  output logic [7:0]        shot_cnt,
  output logic [7:0]        miss_cnt,
  output logic              done_irq
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_DONE    = 3'd4,
    S_HOLDOFF = 3'd5
  } state_t;

  localparam logic [9:0] FILL_LAST = 10'd1023;

  state_t                  r_state, w_state_nxt;
  logic [9:0]              r_cnt, w_cnt_nxt;
  logic [HOLD_W-1:0]       r_hold, w_hold_nxt;
  logic [5:0][QUAL_W-1:0]  r_qual, w_qual_nxt;
  logic [5:0]              r_rec_det, w_rec_det_nxt;
  logic [7:0]              r_rec_ctl, w_rec_ctl_nxt;
  logic [5:0]              r_trig_chan, w_trig_chan_nxt;
  logic [7:0]              r_shot_cnt, w_shot_cnt_nxt;
  logic [7:0]              r_miss_cnt, w_miss_cnt_nxt;
  logic                    r_done_irq, w_done_irq_nxt;
  logic [2:0]              r_rd_sync;

  logic                    w_abort;
  logic                    w_any_hit;
  logic                    w_rd_done;
  logic                    w_miss_state;
  logic                    w_hold_exit;
  logic [5:0]              w_active;
  logic [5:0]              w_hit;
  logic [QUAL_W-1:0]       w_qual_tgt;
  logic [9:0]              w_post_last;
  logic [HOLD_W-1:0]       w_hold_last;

  assign w_abort      = ~cfg_enable | abort_pulse;
  // [0],[1] are the synchronizer pair, [2] holds the previous synced level
  assign w_rd_done    = r_rd_sync[1] ^ r_rd_sync[2];
  assign w_post_last  = {cfg_depth, 2'b00} + 10'd1;
  assign w_hold_last  = cfg_holdoff - HOLD_W'(1);
  assign w_hold_exit  = (cfg_holdoff == '0) || (r_hold == w_hold_last);
  assign w_miss_state = r_state inside {S_FILL, S_POST, S_DONE, S_HOLDOFF};
  assign w_any_hit    = |w_hit;

  // A channel qualifies only on the cycle its counter steps onto the target,
  // so a held-high input triggers once.
  always_comb begin
    w_qual_tgt = (cfg_qual_len == '0) ? '0 : cfg_qual_len - QUAL_W'(1);
    w_active   = det & cfg_mask;
    w_hit      = '0;
    w_qual_nxt = '0;
    for (int i = 0; i < 6; i++) begin
      if ((r_state != S_IDLE) && !w_abort && w_active[i]) begin
        w_hit[i]      = (r_qual[i] == w_qual_tgt);
        w_qual_nxt[i] = (r_qual[i] == '1) ? r_qual[i] : r_qual[i] + QUAL_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_hold_nxt      = r_hold;
    w_rec_det_nxt   = '0;
    w_trig_chan_nxt = r_trig_chan;
    w_shot_cnt_nxt  = r_shot_cnt;
    w_miss_cnt_nxt  = r_miss_cnt;
    w_done_irq_nxt  = 1'b0;
    w_rec_ctl_nxt   = 8'h00;

    if (w_abort) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_hold_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (arm_pulse) begin
            w_state_nxt = S_FILL;
            w_cnt_nxt   = '0;
          end
        end
        S_FILL: begin
          if (r_cnt == FILL_LAST) begin
            w_state_nxt = S_ARMED;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 10'd1;
          end
        end
        S_ARMED: begin
          if (w_any_hit) begin
            w_state_nxt     = S_POST;
            w_rec_det_nxt   = w_hit;
            w_trig_chan_nxt = w_hit;
            w_cnt_nxt       = '0;
          end
        end
        S_POST: begin
          if (r_cnt == w_post_last) begin
            w_state_nxt    = S_DONE;
            w_shot_cnt_nxt = r_shot_cnt + 8'd1;
            w_done_irq_nxt = 1'b1;
            w_cnt_nxt      = '0;
          end else begin
            w_cnt_nxt = r_cnt + 10'd1;
          end
        end
        S_DONE: begin
          if (host_ack || w_rd_done) begin
            w_state_nxt = S_HOLDOFF;
            w_hold_nxt  = '0;
          end
        end
        S_HOLDOFF: begin
          if (w_hold_exit) begin
            w_state_nxt = cfg_auto_rearm ? S_FILL : S_IDLE;
            w_hold_nxt  = '0;
            w_cnt_nxt   = '0;
          end else begin
            w_hold_nxt = r_hold + HOLD_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_hold_nxt  = '0;
        end
      endcase

      if (w_any_hit && w_miss_state && (r_miss_cnt != 8'hFF)) begin
        w_miss_cnt_nxt = r_miss_cnt + 8'd1;
      end
    end

    // rec_ctl follows the state being entered so it changes on the same edge
    case (w_state_nxt)
      S_FILL, S_POST: w_rec_ctl_nxt = 8'h80;
      S_ARMED:        w_rec_ctl_nxt = 8'hBF;
      default:        w_rec_ctl_nxt = 8'h00;
    endcase
  end

  always_ff @(posedge clk8M or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_qual      <= '0;
      r_rec_det   <= '0;
      r_rec_ctl   <= '0;
      r_trig_chan <= '0;
      r_shot_cnt  <= '0;
      r_miss_cnt  <= '0;
      r_done_irq  <= 1'b0;
      r_rd_sync   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hold      <= w_hold_nxt;
      r_qual      <= w_qual_nxt;
      r_rec_det   <= w_rec_det_nxt;
      r_rec_ctl   <= w_rec_ctl_nxt;
      r_trig_chan <= w_trig_chan_nxt;
      r_shot_cnt  <= w_shot_cnt_nxt;
      r_miss_cnt  <= w_miss_cnt_nxt;
      r_done_irq  <= w_done_irq_nxt;
      r_rd_sync   <= {r_rd_sync[1:0], rd_done_tgl};
    end
  end

  assign rec_det   = r_rec_det;
  assign rec_ctl   = r_rec_ctl;
  assign state_o   = r_state;
  assign trig_chan = r_trig_chan;
  assign shot_cnt  = r_shot_cnt;
  assign miss_cnt  = r_miss_cnt;
  assign done_irq  = r_done_irq;

endmodule
